// File: rtl/branch_resolve_unit_if.sv
// Branch resolve bus: decode lookup, execute resolution, redirect and statistics.
// master: pipeline side (drives decode/execute branch info, consumes redirect).
// slave : branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic              dec_is_branch;
  logic [XLEN-1:0]   dec_pc;
  logic [XLEN-1:0]   dec_target;
  logic              dec_pred_taken;
  logic              ex_is_branch;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_taken;
  logic [XLEN-1:0]   ex_target;
  logic              ex_pred_taken;
  logic              stat_clear;
  logic              branch_taken;
  logic              branch_mispredicted;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mispred_count;

  modport master (
    output dec_is_branch, dec_pc, dec_target,
    output ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, stat_clear,
    input  dec_pred_taken, branch_taken, branch_mispredicted,
    input  redirect_valid, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  dec_is_branch, dec_pc, dec_target,
    input  ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, stat_clear,
    output dec_pred_taken, branch_taken, branch_mispredicted,
    output redirect_valid, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 2-bit saturating-counter BHT lookup in decode, branch
// resolution and training in execute, redirect PC selection for fetch, and
// saturating branch/misprediction statistics.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - branch_resolve_unit_if.slave (decode/execute inputs, stat_clear,
//           prediction, flush events, redirect and statistics outputs)
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int INDEX_W = 4,
  parameter int STAT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_resolve_unit_if.slave   bus
);

  localparam int BHT_ENTRIES = 2 ** INDEX_W;

  function automatic logic [1:0] bht_train(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken) begin
      if (c != 2'b11) n = c + 2'd1;
    end else begin
      if (c != 2'b00) n = c - 2'd1;
    end
    return n;
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [1:0]         r_bht [BHT_ENTRIES];
  logic [STAT_W-1:0]  r_br_count;
  logic [STAT_W-1:0]  r_mispred_count;

  logic [INDEX_W-1:0] w_dec_idx;
  logic [INDEX_W-1:0] w_ex_idx;
  logic               w_pred;
  logic               w_mispred;
  logic               w_taken;
  logic [XLEN-1:0]    w_ex_fallthru;
  logic [XLEN-1:0]    w_redirect_pc;
  logic               w_unused_dec_pc;

  assign w_dec_idx       = bus.dec_pc[INDEX_W+1:2];
  assign w_ex_idx        = bus.ex_pc[INDEX_W+1:2];
  assign w_unused_dec_pc = &{1'b0, bus.dec_pc[XLEN-1:INDEX_W+2], bus.dec_pc[1:0]};

  // All combinational outputs are held at 0 while reset is low.
  assign w_pred        = reset & bus.dec_is_branch & r_bht[w_dec_idx][1];
  assign w_mispred     = reset & bus.ex_is_branch & (bus.ex_taken != bus.ex_pred_taken);
  // A mispredict squashes the younger decode instruction and its redirect.
  assign w_taken       = w_pred & ~w_mispred;
  assign w_ex_fallthru = bus.ex_pc + XLEN'(4);

  always_comb begin
    w_redirect_pc = '0;
    if (w_mispred)
      w_redirect_pc = bus.ex_taken ? bus.ex_target : w_ex_fallthru;
    else if (w_taken)
      w_redirect_pc = bus.dec_target;
  end

  assign bus.dec_pred_taken      = w_pred;
  assign bus.branch_taken        = w_taken;
  assign bus.branch_mispredicted = w_mispred;
  assign bus.redirect_valid      = w_taken | w_mispred;
  assign bus.redirect_pc         = w_redirect_pc;
  assign bus.br_count            = r_br_count;
  assign bus.mispred_count       = r_mispred_count;

  // BHT training; decode reads the pre-update value in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (bus.ex_is_branch) begin
      r_bht[w_ex_idx] <= bht_train(r_bht[w_ex_idx], bus.ex_taken);
    end
  end

  // Statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (bus.stat_clear) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (bus.ex_is_branch) begin
      r_br_count <= stat_inc(r_br_count);
      if (w_mispred) r_mispred_count <= stat_inc(r_mispred_count);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for the main sequence,
// hand-written sequences for training, mid-stream reset and counter saturation.
module tb_branch_resolve_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  branch_resolve_unit_if #(.XLEN(32), .STAT_W(16)) u_if ();
  branch_resolve_unit_if #(.XLEN(32), .STAT_W(4))  u_if4 ();

  branch_resolve_unit #(.XLEN(32), .INDEX_W(4), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  branch_resolve_unit #(.XLEN(32), .INDEX_W(4), .STAT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dib;
    logic [31:0] dpc;
    logic [31:0] dtg;
    logic        eib;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etg;
    logic        ep;
    logic        sc;
    logic        xpred;
    logic        xtaken;
    logic        xmis;
    logic        xrv;
    logic [31:0] xrpc;
    logic [15:0] xbr;
    logic [15:0] xmp;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input logic dib, input logic [31:0] dpc, input logic [31:0] dtg,
    input logic eib, input logic [31:0] epc, input logic et, input logic [31:0] etg,
    input logic ep, input logic sc,
    input logic xpred, input logic xtaken, input logic xmis, input logic xrv,
    input logic [31:0] xrpc, input logic [15:0] xbr, input logic [15:0] xmp);
    vec_t v;
    v.dib = dib; v.dpc = dpc; v.dtg = dtg;
    v.eib = eib; v.epc = epc; v.et = et; v.etg = etg; v.ep = ep; v.sc = sc;
    v.xpred = xpred; v.xtaken = xtaken; v.xmis = xmis; v.xrv = xrv;
    v.xrpc = xrpc; v.xbr = xbr; v.xmp = xmp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag,
    input logic xpred, input logic xtaken, input logic xmis, input logic xrv,
    input logic [31:0] xrpc, input logic [15:0] xbr, input logic [15:0] xmp);
    chk({tag, ".dec_pred_taken"},      32'(u_if.dec_pred_taken),      32'(xpred));
    chk({tag, ".branch_taken"},        32'(u_if.branch_taken),        32'(xtaken));
    chk({tag, ".branch_mispredicted"}, 32'(u_if.branch_mispredicted), 32'(xmis));
    chk({tag, ".redirect_valid"},      32'(u_if.redirect_valid),      32'(xrv));
    chk({tag, ".redirect_pc"},         u_if.redirect_pc,              xrpc);
    chk({tag, ".br_count"},            32'(u_if.br_count),            32'(xbr));
    chk({tag, ".mispred_count"},       32'(u_if.mispred_count),       32'(xmp));
  endtask

  task automatic idle();
    u_if.dec_is_branch = 1'b0; u_if.dec_pc = '0; u_if.dec_target = '0;
    u_if.ex_is_branch  = 1'b0; u_if.ex_pc  = '0; u_if.ex_taken   = 1'b0;
    u_if.ex_target     = '0;   u_if.ex_pred_taken = 1'b0; u_if.stat_clear = 1'b0;
  endtask

  task automatic idle4();
    u_if4.dec_is_branch = 1'b0; u_if4.dec_pc = '0; u_if4.dec_target = '0;
    u_if4.ex_is_branch  = 1'b0; u_if4.ex_pc  = '0; u_if4.ex_taken   = 1'b0;
    u_if4.ex_target     = '0;   u_if4.ex_pred_taken = 1'b0; u_if4.stat_clear = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic pred);
    u_if.ex_is_branch = 1'b1; u_if.ex_pc = pc; u_if.ex_taken = taken;
    u_if.ex_target = tgt; u_if.ex_pred_taken = pred;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              dib dpc       dtg       eib epc          et etg       ep sc  pred tkn mis rv  rpc       br  mp
    vecs[0]  = mk(1, 32'h100, 32'h500, 0, 32'h0,        0, 32'h0,    0, 0,  0, 0, 0, 0, 32'h0,   0, 0);
    vecs[1]  = mk(0, 32'h0,   32'h0,   1, 32'h100,      1, 32'h180,  0, 0,  0, 0, 1, 1, 32'h180, 0, 0);
    vecs[2]  = mk(0, 32'h0,   32'h0,   1, 32'h100,      1, 32'h180,  0, 0,  0, 0, 1, 1, 32'h180, 1, 1);
    vecs[3]  = mk(1, 32'h100, 32'h500, 0, 32'h0,        0, 32'h0,    0, 0,  1, 1, 0, 1, 32'h500, 2, 2);
    vecs[4]  = mk(1, 32'h100, 32'h500, 1, 32'h200,      0, 32'h300,  1, 0,  1, 0, 1, 1, 32'h204, 2, 2);
    vecs[5]  = mk(1, 32'h140, 32'h600, 1, 32'h100,      0, 32'h180,  0, 0,  1, 1, 0, 1, 32'h600, 3, 3);
    vecs[6]  = mk(1, 32'h140, 32'h600, 0, 32'h0,        0, 32'h0,    0, 0,  0, 0, 0, 0, 32'h0,   4, 3);
    vecs[7]  = mk(0, 32'h0,   32'h0,   1, 32'h10,       1, 32'h40,   0, 1,  0, 0, 1, 1, 32'h40,  4, 3);
    vecs[8]  = mk(0, 32'h0,   32'h0,   1, 32'hFFFFFFFC, 0, 32'h1234, 1, 0,  0, 0, 1, 1, 32'h0,   0, 0);
    vecs[9]  = mk(1, 32'h10,  32'h777, 1, 32'h3C,       0, 32'h99,   0, 0,  1, 1, 0, 1, 32'h777, 1, 1);
    vecs[10] = mk(1, 32'h3C,  32'h888, 0, 32'h0,        0, 32'h0,    0, 0,  0, 0, 0, 0, 32'h0,   2, 1);

    reset = 1'b0;
    idle();
    idle4();
    // Outputs forced low during reset even with active branch inputs.
    u_if.dec_is_branch = 1'b1; u_if.dec_pc = 32'h100; u_if.dec_target = 32'h500;
    set_ex(32'h200, 1'b0, 32'h300, 1'b1);
    #3;
    check_outs("in_reset", 0, 0, 0, 0, 32'h0, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    idle();

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      u_if.dec_is_branch = vecs[i].dib;
      u_if.dec_pc        = vecs[i].dpc;
      u_if.dec_target    = vecs[i].dtg;
      u_if.ex_is_branch  = vecs[i].eib;
      u_if.ex_pc         = vecs[i].epc;
      u_if.ex_taken      = vecs[i].et;
      u_if.ex_target     = vecs[i].etg;
      u_if.ex_pred_taken = vecs[i].ep;
      u_if.stat_clear    = vecs[i].sc;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].xpred, vecs[i].xtaken, vecs[i].xmis,
                 vecs[i].xrv, vecs[i].xrpc, vecs[i].xbr, vecs[i].xmp);
    end

    // Train idx 4 (10->11) and idx 0 (01->10->11) with correct predictions.
    @(negedge clk);
    idle();
    set_ex(32'h10, 1'b1, 32'h40, 1'b1);
    repeat (2) @(negedge clk);
    set_ex(32'h100, 1'b1, 32'h180, 1'b1);
    repeat (2) @(negedge clk);
    idle();
    u_if.dec_is_branch = 1'b1; u_if.dec_pc = 32'h100; u_if.dec_target = 32'hA00;
    #1;
    check_outs("trained_idx0", 1, 1, 0, 1, 32'hA00, 6, 1);
    u_if.dec_pc = 32'h10; u_if.dec_target = 32'hB00;
    #1;
    check_outs("trained_idx4", 1, 1, 0, 1, 32'hB00, 6, 1);

    // Asynchronous reset mid-cycle with branch activity on both stages.
    #1;
    set_ex(32'h10, 1'b0, 32'h40, 1'b1);
    reset = 1'b0;
    #1;
    check_outs("mid_reset", 0, 0, 0, 0, 32'h0, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    idle();
    for (int i = 0; i < 16; i++) begin
      u_if.dec_is_branch = 1'b1;
      u_if.dec_pc        = 32'(i) << 2;
      u_if.dec_target    = 32'hC00;
      #1;
      chk($sformatf("post_reset_pred_idx%0d", i), 32'(u_if.dec_pred_taken), 32'h0);
    end
    idle();

    // Saturation on a 4-bit statistics instance: every resolve mispredicts.
    @(negedge clk);
    u_if4.ex_is_branch = 1'b1; u_if4.ex_pc = 32'h20; u_if4.ex_taken = 1'b1;
    u_if4.ex_target = 32'h80; u_if4.ex_pred_taken = 1'b0;
    repeat (15) @(negedge clk);
    chk("sat4_br_at_max",      32'(u_if4.br_count),      32'hF);
    chk("sat4_mp_at_max",      32'(u_if4.mispred_count), 32'hF);
    repeat (5) @(negedge clk);
    chk("sat4_br_hold",        32'(u_if4.br_count),      32'hF);
    chk("sat4_mp_hold",        32'(u_if4.mispred_count), 32'hF);
    u_if4.stat_clear = 1'b1;
    @(negedge clk);
    chk("sat4_br_clear",       32'(u_if4.br_count),      32'h0);
    chk("sat4_mp_clear",       32'(u_if4.mispred_count), 32'h0);
    u_if4.stat_clear = 1'b0;
    @(negedge clk);
    chk("sat4_br_after_clear", 32'(u_if4.br_count),      32'h1);
    chk("sat4_mp_after_clear", 32'(u_if4.mispred_count), 32'h1);
    idle4();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
